// File: rtl/axil_seq_initiator.sv
// ---------------------------------------------------------------------------
// axil_seq_initiator
//
// AXI-Lite initiator that walks a run of consecutive word addresses, doing
// one single-beat write or read per word. There is never more than one
// AXI-Lite transaction in flight.
//
//   Write sequence: each word is taken from the s_axis sink, then AW and W are
//   issued together, then the B response is collected.
//   Read sequence:  each AR/R pair lands in a one-word output register that
//   feeds m_axis. tlast marks the final word. The next AR may be issued
//   while the previous word is still waiting in that register.
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   cmd_*               command: direction, start byte address, word count
//   busy / done / err   status: done pulses once per sequence, and err is
//                       valid with done (any bresp[1]/rresp[1] seen)
//   s_axis_*            write-data stream in
//   m_axis_*            read-data stream out (with tlast)
//   m_axil_aw*/w*/b*    AXI-Lite write channels
//   m_axil_ar*/r*       AXI-Lite read channels
// ---------------------------------------------------------------------------
module axil_seq_initiator #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,

  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_DRAIN,
    FINISH
  } state_t;

  // One word is STRB_WIDTH bytes. Addresses stay word aligned and wrap
  // modulo 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_STEP - ADDR_WIDTH'(1));

  state_t                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q,       cnt_d;
  logic                  err_acc_q,   err_acc_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic                  awvalid_q,   awvalid_d;
  logic                  wvalid_q,    wvalid_d;
  logic                  arvalid_q,   arvalid_d;
  logic [DATA_WIDTH-1:0] m_tdata_q,   m_tdata_d;
  logic                  m_tvalid_q,  m_tvalid_d;
  logic                  m_tlast_q,   m_tlast_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  err_q,       err_d;

  logic last_word;

  // Only bit 1 of a response (SLVERR/DECERR) matters here.
  logic unused_resp_lsbs;
  assign unused_resp_lsbs = m_axil_bresp[0] ^ m_axil_rresp[0];

  assign last_word = (cnt_q == LEN_WIDTH'(1));

  // Handshake readies decode straight from registered state. cmd_ready stays
  // low during the done cycle, so a new command cannot overlap the pulse.
  assign cmd_ready     = (state_q == IDLE) && !done_q;
  assign s_axis_tready = (state_q == WR_FETCH);
  assign m_axil_bready = (state_q == WR_RESP);
  // Accept a read beat only when the output register is free. The beat is
  // never dropped, at the cost of one bubble after a drain.
  assign m_axil_rready = (state_q == RD_WAIT) && !m_tvalid_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_arvalid = arvalid_q;
  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tlast   = m_tlast_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_acc_d  = err_acc_q;
    wdata_d    = wdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // The output register drains on its own, whatever the sequencer is doing.
    // This is what lets the next AR go out while a word is still queued.
    if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end

    // busy covers the done cycle, then drops.
    if (done_q) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr & ADDR_MASK;
          cnt_d     = cmd_len;
          err_acc_d = 1'b0;
          busy_d    = 1'b1;
          if (cmd_len == '0) begin
            state_d = FINISH;
          end else if (cmd_write) begin
            state_d = WR_FETCH;
          end else begin
            state_d   = RD_ISSUE;
            arvalid_d = 1'b1;
          end
        end
      end

      WR_FETCH: begin
        if (s_axis_tvalid) begin
          wdata_d   = s_axis_tdata;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_ISSUE;
        end
      end

      WR_ISSUE: begin
        // AW and W complete independently. Move on once both have gone.
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axil_bvalid) begin
          err_acc_d = err_acc_q | m_axil_bresp[1];
          cnt_d     = cnt_q - LEN_WIDTH'(1);
          addr_d    = addr_q + ADDR_STEP;
          state_d   = last_word ? FINISH : WR_FETCH;
        end
      end

      RD_ISSUE: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (m_axil_rvalid && m_axil_rready) begin
          m_tdata_d  = m_axil_rdata;
          m_tvalid_d = 1'b1;
          m_tlast_d  = last_word;
          err_acc_d  = err_acc_q | m_axil_rresp[1];
          cnt_d      = cnt_q - LEN_WIDTH'(1);
          addr_d     = addr_q + ADDR_STEP;
          if (last_word) begin
            state_d = RD_DRAIN;
          end else begin
            state_d   = RD_ISSUE;
            arvalid_d = 1'b1;
          end
        end
      end

      RD_DRAIN: begin
        if (m_tvalid_q && m_axis_tready) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        err_d   = err_acc_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments, so every flop samples
    // the values from before this edge no matter what order the updates run in.
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_acc_q  <= 1'b0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_acc_q  <= err_acc_d;
      wdata_q    <= wdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/axil_seq_initiator.md
Name: axil_seq_initiator

Overview:
AXI-Lite initiator (master) that executes a sequence of single-beat writes or reads over consecutive word addresses, driven by a command interface. In write mode, data comes from an AXI-Stream sink. In read mode, data goes to an AXI-Stream source with tlast on the final word. Used by compute blocks to fill or drain the dual-port AXI-Lite RAMs without a processor; at most one AXI-Lite transaction is outstanding at any time.

Parameters:
ADDR_WIDTH, 9, byte address width of the AXI-Lite bus
DATA_WIDTH, 32, AXI-Lite and stream data width (multiple of 8)
STRB_WIDTH, DATA_WIDTH/8, write strobe width; also the address increment per word
LEN_WIDTH, 8, width of the word-count field

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write sequence, 0 = read sequence
cmd_addr  in  ADDR_WIDTH  start byte address (low log2(STRB_WIDTH) bits ignored, forced 0)
cmd_len  in  LEN_WIDTH  number of words; 0 = no bus activity
busy  out  1  high from command acceptance until done
done  out  1  one-cycle pulse when the sequence completes
err  out  1  valid with done; 1 if any bresp/rresp[1] was set during the sequence
s_axis_tdata / tvalid / tready  in/in/out  DATA_WIDTH/1/1  write-data stream
m_axis_tdata / tvalid / tready / tlast  out/out/in/out  DATA_WIDTH/1/1/1  read-data stream
m_axil_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1
m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/STRB_WIDTH/1/1
m_axil_bresp/bvalid/bready  in/in/out  2/1/1
m_axil_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1
m_axil_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1

Behaviour:
- Reset: state IDLE. cmd_ready=1. All other outputs 0: busy, done, err, all valids, bready, rready, s_axis_tready, m_axis_tvalid, tlast. Reset mid-sequence abandons it; no done pulse.
- awprot=arprot=3'b000; wstrb all ones.
- States: IDLE, WR_FETCH, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_DRAIN, FINISH.
- IDLE: cmd_ready=1. On handshake, latch addr, remaining count and direction; clear error accumulator; set busy. Next state: FINISH if len=0, else WR_FETCH or RD_ISSUE.
- WR_FETCH: s_axis_tready=1. On beat, register data. Next: WR_ISSUE with awvalid=wvalid=1.
- WR_ISSUE: awvalid and wvalid each drop independently on their own handshake (either order, or the same cycle). Once both are done: bready=1, go to WR_RESP.
- WR_RESP: on bvalid, OR bresp[1] into the error accumulator, decrement count, add STRB_WIDTH to addr. Next: FINISH if count hits 0, else WR_FETCH.
- RD_ISSUE: arvalid=1 until arready, then RD_WAIT.
- RD_WAIT: rready=1 only while the output register is empty. On rvalid&&rready: capture rdata; set m_axis_tvalid; tlast=1 if this is the final word; accumulate rresp[1]; decrement count; advance addr. Next: RD_DRAIN if final, else RD_ISSUE.
- Read pipelining: the next arvalid may be issued while the previous word waits in the output register. Only one AR is ever outstanding.
- m_axis_tvalid holds with stable tdata/tlast until tready.
- RD_DRAIN: wait for the final m_axis handshake, then FINISH.
- FINISH: one cycle. done=1, err=accumulator, busy=0 from the next cycle. Return to IDLE; cmd_ready=1 again from the cycle after done.
- Address arithmetic: addr+STRB_WIDTH modulo 2^ADDR_WIDTH; wraps 0x1FC -> 0x000 for defaults.
- Error responses do not abort the sequence; all words are transferred.
- Latency: with zero-wait slave and sink, a write word costs 3 cycles (fetch, issue, resp); a read word costs 2 (issue, wait).

Test Plan:
- Write len=4, addr=0x010, stream 0xA0..0xA3, slave always ready, bresp=0 -> AW addrs 0x010,0x014,0x018,0x01C carry the matching wdata; one done pulse with err=0; busy high throughout.
- Read len=3, addr=0x020, slave returns 0x11,0x22,0x33, m_axis_tready stalls 5 cycles on word 2 -> stream 0x11,0x22,0x33 in order, tlast only on 0x33, no data lost, rready low while output register full.
- Write with awready delayed 3 cycles after wready -> wvalid drops immediately after its handshake; awvalid stays high until its handshake; one bready handshake; done after len words.
- Read len=2 from addr=0x1FC, second rresp=2'b10 -> araddr 0x1FC then 0x000; done with err=1; both words delivered.
- len=0 command -> no AXI-Lite or stream activity; done pulse 2 cycles after cmd handshake; err=0.
- rst asserted while in WR_ISSUE -> next cycle all valids 0, state IDLE, cmd_ready=1, no done; the following command executes normally.
